// File: rtl/scope_pkg.sv
// Shared types and constants for the scope acquisition sequencer.
// Holds the FSM state encoding, the mode encodings and the default widths.
package scope_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_STOP   = 2'b11;

    // True in the states where incoming samples go into the RAM.
    function automatic logic is_acquiring(state_t s);
        return (s == ST_PRETRIG) || (s == ST_ARMED) || (s == ST_POSTTRIG);
    endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Level/edge trigger detector: keeps the last accepted sample and compares it
// with the current sample against the threshold. hit is combinational on cur.
module scope_trig_detect #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              en,
    output logic              hit
);

    logic [DATA_W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else if (sample_valid && en) begin
            prev <= sample_data;
        end
    end

    always_comb begin
        hit = 1'b0;
        if (trig_rising) begin
            hit = (prev < trig_level) && (sample_data >= trig_level);
        end else begin
            hit = (prev > trig_level) && (sample_data <= trig_level);
        end
    end

endmodule

// File: rtl/scope_acq_ctrl.sv
// Acquisition sequencer: streams ADC samples into a circular RAM, waits for a
// trigger, captures a fixed pre/post window and freezes it for readout.
module scope_acq_ctrl
    import scope_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int PRETRIG = 64,
    parameter int AUTO_TO = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [1:0]        mode,
    input  logic              arm,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              triggered,
    output logic              frame_ready,
    output logic [ADDR_W-1:0] frame_start,
    input  logic              frame_ack,
    output logic [2:0]        state_o
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int POST_N = DEPTH - PRETRIG;
    localparam int TO_W   = $clog2(AUTO_TO + 1);

    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(PRETRIG - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TO - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TO);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic acq, stop, wr, hit, auto_fire, trig_fire;

    assign acq  = is_acquiring(state);
    assign stop = (mode == MODE_STOP);
    // Stop wins over a sample arriving on the same edge: that sample is dropped.
    assign wr   = sample_valid && acq && !stop;

    // The timeout saturates so a later switch into auto mode fires on the next sample.
    assign auto_fire = (mode == MODE_AUTO) && (to_cnt >= TO_LAST);
    assign trig_fire = (state == ST_ARMED) && wr && (hit || auto_fire);

    scope_trig_detect #(
        .DATA_W(DATA_W)
    ) u_trig (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .en           (acq),
        .hit          (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mode == MODE_AUTO || mode == MODE_NORMAL) begin
                        state_nxt = ST_PRETRIG;
                    end else if (mode == MODE_SINGLE && arm) begin
                        state_nxt = ST_PRETRIG;
                    end
                end
                ST_PRETRIG: begin
                    if (wr && fill_cnt == FILL_LAST) state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_fire) state_nxt = (POST_N == 1) ? ST_HOLD : ST_POSTTRIG;
                end
                ST_POSTTRIG: begin
                    if (wr && post_cnt == POST_LAST) state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (frame_ack) state_nxt = (mode == MODE_SINGLE) ? ST_IDLE : ST_PRETRIG;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ready = (state == ST_HOLD);
        state_o     = state;
    end

    // Fill and timeout counts restart on every entry to their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
            post_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (state != ST_PRETRIG) begin
                fill_cnt <= '0;
            end else if (wr) begin
                fill_cnt <= fill_cnt + 1'b1;
            end

            if (trig_fire) begin
                post_cnt <= ADDR_W'(1);
            end else if (state == ST_POSTTRIG && wr) begin
                post_cnt <= post_cnt + 1'b1;
            end

            if (state != ST_ARMED) begin
                to_cnt <= '0;
            end else if (sample_valid && to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // Write port: one cycle behind sample_valid; the address keeps running across frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr       <= '0;
            buf_we      <= 1'b0;
            buf_waddr   <= '0;
            buf_wdata   <= '0;
            triggered   <= 1'b0;
            frame_start <= '0;
        end else begin
            buf_we    <= wr;
            triggered <= trig_fire;
            if (wr) begin
                buf_waddr <= waddr;
                buf_wdata <= sample_data;
                waddr     <= waddr + 1'b1;
            end
            if (trig_fire) begin
                frame_start <= waddr - PRE_OFS;
            end
        end
    end

endmodule

// File: tb/tb_scope_acq_ctrl.sv
// Bench for scope_acq_ctrl: a frame-level model predicts every RAM write and
// frame start; a separate monitor pops and compares whenever the DUT writes.
module tb_scope_acq_ctrl;

  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int PT     = 4;
  localparam int ATO    = 8;
  localparam int DEPTH  = 16;
  localparam int POST_N = DEPTH - PT;
  localparam int EW     = 1 + AW + DW;

  localparam logic [1:0] M_AUTO   = 2'b00;
  localparam logic [1:0] M_NORMAL = 2'b01;
  localparam logic [1:0] M_SINGLE = 2'b10;
  localparam logic [1:0] M_STOP   = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic [DW-1:0] trig_level;
  logic          trig_rising;
  logic [1:0]    mode;
  logic          arm;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic          triggered;
  logic          frame_ready;
  logic [AW-1:0] frame_start;
  logic          frame_ack;
  logic [2:0]    state_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] fs_q[$];

  // Frame-level reference model
  bit            m_idle   = 1'b1;
  bit            m_active = 1'b0;
  bit            m_hold   = 1'b0;
  int            m_n      = 0;
  int            m_trig   = -1;
  int            m_waddr  = 0;
  logic [AW-1:0] m_fs     = '0;
  logic [DW-1:0] m_prev   = '0;

  scope_acq_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .PRETRIG(PT), .AUTO_TO(ATO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_level(trig_level), .trig_rising(trig_rising), .mode(mode), .arm(arm),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .triggered(triggered),
    .frame_ready(frame_ready), .frame_start(frame_start), .frame_ack(frame_ack),
    .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Expected debug state, derived from the frame bookkeeping.
  function automatic int model_state();
    if (m_idle) return 0;
    if (m_hold) return 4;
    if (m_trig >= 0) return 3;
    if (m_n >= PT) return 2;
    return 1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    m_idle = 1'b0; m_active = 1'b1; m_hold = 1'b0; m_n = 0; m_trig = -1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'(model_state()));
    chk({tag, "_frame_ready"}, 32'(frame_ready), 32'(m_hold));
  endtask

  task automatic model_sample(input logic [DW-1:0] d);
    bit edge_hit, trig;
    if (trig_rising) edge_hit = (m_prev < trig_level) && (d >= trig_level);
    else             edge_hit = (m_prev > trig_level) && (d <= trig_level);
    trig = (m_trig < 0) && (m_n >= PT) &&
           (edge_hit || (mode == M_AUTO && (m_n - PT + 1) >= ATO));
    exp_q.push_back({trig, AW'(m_waddr), d});
    if (trig) begin
      m_trig = m_n;
      m_fs   = AW'((m_waddr - PT + DEPTH) % DEPTH);
    end
    m_n++;
    m_waddr = (m_waddr + 1) % DEPTH;
    m_prev  = d;
    if (m_trig >= 0 && (m_n - m_trig) >= POST_N) begin
      m_active = 1'b0;
      m_hold   = 1'b1;
      fs_q.push_back(m_fs);
    end
  endtask

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input bit with_stop);
    sample_valid = 1'b1;
    sample_data  = d;
    if (with_stop) begin
      mode = M_STOP;
      m_idle = 1'b1; m_active = 1'b0; m_hold = 1'b0;
    end else if (m_active) begin
      model_sample(d);
    end
    step(1);
    sample_valid = 1'b0;
    step(3);
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode = m;
    if (m == M_STOP) begin
      m_idle = 1'b1; m_active = 1'b0; m_hold = 1'b0;
    end else if (m_idle && m != M_SINGLE) begin
      start_frame();
    end
    step(2);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
    if (m_idle && mode == M_SINGLE) start_frame();
    step(1);
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    step(1);
    frame_ack = 1'b0;
    if (m_hold) begin
      if (mode == M_SINGLE) begin
        m_idle = 1'b1; m_hold = 1'b0;
      end else begin
        start_frame();
      end
    end
    step(1);
  endtask

  // Random samples until the frame freezes; late samples swing rail to rail to force an edge.
  task automatic run_frame();
    logic [DW-1:0] d;
    for (int i = 0; i < 80 && !m_hold && m_active; i++) begin
      if (i == 7 && (mode == M_AUTO || mode == M_NORMAL)) set_mode(mode ^ 2'b01);
      if (i >= 50) d = (i % 2 == 1) ? 8'hFF : 8'h00;
      else         d = DW'($urandom_range(0, 255));
      send(d, 1'b0);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    logic          fr_d;
    fr_d = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (buf_we) begin
          if (exp_q.size() == 0) begin
            chk("write_unexpected", 32'({triggered, buf_waddr, buf_wdata}), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("write", 32'({triggered, buf_waddr, buf_wdata}), 32'(e));
          end
        end else if (triggered) begin
          chk("trig_without_write", 32'(triggered), 32'(0));
        end
        if (frame_ready && !fr_d) begin
          if (fs_q.size() == 0) chk("frame_unexpected", 32'(frame_start), 32'hFFFF_FFFF);
          else                  chk("frame_start", 32'(frame_start), 32'(fs_q.pop_front()));
        end
        fr_d = frame_ready;
      end
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0; sample_valid = 1'b0; sample_data = '0; trig_level = 8'h80;
    trig_rising = 1'b1; mode = M_STOP; arm = 1'b0; frame_ack = 1'b0;
    step(3);
    chk("rst_buf_we", 32'(buf_we), 32'(0));
    chk("rst_buf_waddr", 32'(buf_waddr), 32'(0));
    chk("rst_buf_wdata", 32'(buf_wdata), 32'(0));
    chk("rst_triggered", 32'(triggered), 32'(0));
    chk("rst_frame_ready", 32'(frame_ready), 32'(0));
    chk("rst_frame_start", 32'(frame_start), 32'(0));
    chk("rst_state", 32'(state_o), 32'(0));
    rst_n = 1'b1;
    step(1);
    mode = M_NORMAL;
    step(1);
    chk("release_to_pretrig", 32'(state_o), 32'(1));
    start_frame();
    step(1);

    // normal, rising ramp
    for (int i = 0; i < 40 && !m_hold; i++) send(DW'(i * 16), 1'b0);
    chk_status("ramp_hold");
    pulse_ack();
    chk_status("ramp_ack");

    // falling edge, flat input first
    trig_rising = 1'b0;
    repeat (10) send(8'h80, 1'b0);
    chk_status("flat_armed");
    send(8'h90, 1'b0);
    send(8'h80, 1'b0);
    chk_status("fall_post");
    send(8'h70, 1'b0);
    run_frame();
    chk_status("fall_hold");
    pulse_ack();

    // auto, constant input
    set_mode(M_AUTO);
    for (int i = 0; i < 40 && !m_hold; i++) send(8'h33, 1'b0);
    chk_status("auto_hold");
    pulse_ack();
    chk_status("auto_ack");

    // single shot, ignored arm and idle samples
    set_mode(M_STOP);
    chk_status("stop_idle");
    pulse_arm();
    chk_status("arm_in_stop");
    set_mode(M_SINGLE);
    chk_status("single_idle");
    send(8'h55, 1'b0);
    pulse_arm();
    chk_status("single_armed");
    run_frame();
    chk_status("single_hold");
    pulse_ack();
    chk_status("single_ack");
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    pulse_arm();
    run_frame();
    pulse_ack();
    chk_status("single2_ack");

    // stop in POSTTRIG and HOLD, ack in ARMED, stop with a sample in flight
    trig_rising = 1'b1; trig_level = 8'h80;
    set_mode(M_NORMAL);
    repeat (4) send(8'h10, 1'b0);
    chk_status("ack_armed_before");
    pulse_ack();
    chk_status("ack_armed_after");
    send(8'h10, 1'b0);
    send(8'h90, 1'b0);
    repeat (3) send(DW'($urandom_range(0, 255)), 1'b0);
    chk_status("post_before_stop");
    set_mode(M_STOP);
    chk_status("post_stop");
    set_mode(M_NORMAL);
    run_frame();
    chk_status("hold_before_stop");
    set_mode(M_STOP);
    chk_status("hold_stop");
    set_mode(M_NORMAL);
    repeat (4) send(8'h10, 1'b0);
    send(8'hA0, 1'b0);
    send(8'h42, 1'b1);
    chk_status("inflight_stop");

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      trig_level  = DW'($urandom_range(1, 254));
      trig_rising = 1'($urandom_range(0, 1));
      set_mode(2'($urandom_range(0, 1)));
      run_frame();
      chk_status("rand_hold");
      step($urandom_range(0, 5));
      pulse_ack();
      chk_status("rand_ack");
    end

    step(10);
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
    chk("fs_q_drained", 32'(fs_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
